// File: rtl/excess_3_to_bcd_serial_if.sv
// Serial Excess-3 in / BCD out signal bundle for excess_3_to_bcd_serial.
// The master drives the serial input side; the slave is the converter.
interface excess_3_to_bcd_serial_if;
  logic       B_in;
  logic       in_valid;
  logic       sync;
  logic       B_out;
  logic       out_valid;
  logic [3:0] digit;
  logic       digit_valid;
  logic       code_err;

  modport master (
    output B_in,
    output in_valid,
    output sync,
    input  B_out,
    input  out_valid,
    input  digit,
    input  digit_valid,
    input  code_err
  );

  modport slave (
    input  B_in,
    input  in_valid,
    input  sync,
    output B_out,
    output out_valid,
    output digit,
    output digit_valid,
    output code_err
  );
endinterface

// File: rtl/excess_3_to_bcd_serial.sv
// Bit-serial Excess-3 to BCD converter: subtracts 0011 LSB first with a borrow carried
// in the FSM state, and assembles each completed 4-bit digit with an out-of-range flag.
module excess_3_to_bcd_serial (
  input logic                     clk,
  input logic                     reset_b,
  excess_3_to_bcd_serial_if.slave bus_io
);

  localparam logic [2:0] B0    = 3'd0;
  localparam logic [2:0] B1_NB = 3'd1;
  localparam logic [2:0] B1_B  = 3'd2;
  localparam logic [2:0] B2_NB = 3'd3;
  localparam logic [2:0] B2_B  = 3'd4;
  localparam logic [2:0] B3_NB = 3'd5;
  localparam logic [2:0] B3_B  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [2:0] part_q, part_d;
  logic [2:0] xin_q, xin_d;
  logic       bout_q, bout_d;
  logic       ov_q, ov_d;
  logic [3:0] digit_q, digit_d;
  logic       dv_q, dv_d;
  logic       err_q, err_d;

  logic       take;
  logic [2:0] cur_state;
  logic [1:0] pos;
  logic       borrow_in;
  logic       sub_bit;
  logic       x;
  logic       out_bit;
  logic       borrow_next;
  logic [3:0] in_code;

  assign take = bus_io.in_valid;
  assign x    = bus_io.B_in;

  // A qualified sync restarts the digit at bit 0, dropping any partial result.
  assign cur_state = (take && bus_io.sync) ? B0 : state_q;

  always_comb begin
    pos       = 2'd0;
    borrow_in = 1'b0;
    case (cur_state)
      B0:      begin pos = 2'd0; borrow_in = 1'b0; end
      B1_NB:   begin pos = 2'd1; borrow_in = 1'b0; end
      B1_B:    begin pos = 2'd1; borrow_in = 1'b1; end
      B2_NB:   begin pos = 2'd2; borrow_in = 1'b0; end
      B2_B:    begin pos = 2'd2; borrow_in = 1'b1; end
      B3_NB:   begin pos = 2'd3; borrow_in = 1'b0; end
      B3_B:    begin pos = 2'd3; borrow_in = 1'b1; end
      default: begin pos = 2'd0; borrow_in = 1'b0; end
    endcase
  end

  // Subtrahend 0011: ones in the two low positions.
  assign sub_bit     = ~pos[1];
  assign out_bit     = x ^ sub_bit ^ borrow_in;
  assign borrow_next = (~x & (sub_bit | borrow_in)) | (sub_bit & borrow_in);
  assign in_code     = {x, xin_q};

  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    xin_d   = xin_q;
    bout_d  = bout_q;
    ov_d    = take;
    digit_d = digit_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    if (take) begin
      bout_d = out_bit;
      unique case (pos)
        2'd0: begin
          part_d[0] = out_bit;
          xin_d[0]  = x;
          state_d   = borrow_next ? B1_B : B1_NB;
        end
        2'd1: begin
          part_d[1] = out_bit;
          xin_d[1]  = x;
          state_d   = borrow_next ? B2_B : B2_NB;
        end
        2'd2: begin
          part_d[2] = out_bit;
          xin_d[2]  = x;
          state_d   = borrow_next ? B3_B : B3_NB;
        end
        2'd3: begin
          digit_d = {out_bit, part_q};
          dv_d    = 1'b1;
          // Borrow out of bit 3 means the code was below 0011.
          err_d   = borrow_next | (in_code > 4'd12);
          state_d = B0;
        end
        default: state_d = B0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= B0;
      part_q  <= 3'b000;
      xin_q   <= 3'b000;
      bout_q  <= 1'b0;
      ov_q    <= 1'b0;
      digit_q <= 4'b0000;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      xin_q   <= xin_d;
      bout_q  <= bout_d;
      ov_q    <= ov_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.B_out       = bout_q;
  assign bus_io.out_valid   = ov_q;
  assign bus_io.digit       = digit_q;
  assign bus_io.digit_valid = dv_q;
  assign bus_io.code_err    = err_q;

endmodule
